// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-port memory responder: word width and FSM state encodings.
package data_mem_responder_pkg;

    localparam int DEF_WORD_SIZE = 16;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port word array with synchronous write and a registered, reset-to-zero read port.
module dmem_array #(
    parameter int WORD_SIZE = 16,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem_r [MEM_DEPTH];
    logic [WORD_SIZE-1:0] rdata_r;

    // Storage is intentionally not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register holds the last read word until the next read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r <= {WORD_SIZE{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port: accepts one read/write at a time,
// stalls the MEM stage while busy, and pulses d_ready after a fixed latency.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int MEM_DEPTH = 256,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_address,
    input  logic [WORD_SIZE-1:0] d_data_in,
    output logic [WORD_SIZE-1:0] d_data_out,
    output logic                 d_ready,
    output logic                 d_busy,
    output logic                 d_err
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_e          state_r;
    dmem_state_e          state_nxt_s;
    logic [CNT_W-1:0]     count_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [WORD_SIZE-1:0] wdata_r;
    logic                 is_write_r;
    logic                 is_conflict_r;
    logic                 ready_r;
    logic                 err_r;
    logic                 req_s;
    logic                 accept_s;
    logic                 commit_s;
    logic                 busy_s;
    logic                 unused_addr_s;

    assign req_s         = d_readM | d_writeM;
    assign unused_addr_s = ^d_address[WORD_SIZE-1:ADDR_W];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= DMEM_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; commit happens on the edge leaving BUSY.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        commit_s    = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            DMEM_IDLE: begin
                if (req_s) begin
                    accept_s    = 1'b1;
                    busy_s      = 1'b1;
                    state_nxt_s = DMEM_BUSY;
                end else begin
                    state_nxt_s = DMEM_IDLE;
                end
            end
            DMEM_BUSY: begin
                busy_s = 1'b1;
                if (count_r == {CNT_W{1'b0}}) begin
                    commit_s    = 1'b1;
                    state_nxt_s = DMEM_DONE;
                end else begin
                    state_nxt_s = DMEM_BUSY;
                end
            end
            DMEM_DONE: begin
                state_nxt_s = DMEM_IDLE;
            end
            default: begin
                state_nxt_s = DMEM_IDLE;
            end
        endcase
    end

    // Request latches and latency counter; a conflicting request is treated as a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r       <= {CNT_W{1'b0}};
            addr_r        <= {ADDR_W{1'b0}};
            wdata_r       <= {WORD_SIZE{1'b0}};
            is_write_r    <= 1'b0;
            is_conflict_r <= 1'b0;
        end else if (accept_s) begin
            count_r       <= CNT_LOAD;
            addr_r        <= d_address[ADDR_W-1:0];
            wdata_r       <= d_data_in;
            is_write_r    <= d_writeM;
            is_conflict_r <= d_readM & d_writeM;
        end else if ((state_r == DMEM_BUSY) && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_W'(1);
        end
    end

    // Completion pulses are registered so they coincide with the DONE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= commit_s;
            err_r   <= commit_s & is_conflict_r;
        end
    end

    dmem_array #(
        .WORD_SIZE (WORD_SIZE),
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (commit_s & is_write_r),
        .re      (commit_s & ~is_write_r),
        .addr    (addr_r),
        .wdata   (wdata_r),
        .rdata   (d_data_out)
    );

    // Stall must stay low while in reset even if a request is already raised.
    assign d_busy  = reset_n & busy_s;
    assign d_ready = ready_r;
    assign d_err   = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (latency 2, 1, 4) driven by table vectors and hand sequences.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  rd_v;
    logic [2:0]  wr_v;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] dout_a [3];
    logic [2:0]  ready_v;
    logic [2:0]  busy_v;
    logic [2:0]  err_v;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] data;
        bit          chk;
        bit          err;
    } exp_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp_d;
        bit          chk;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   lats[3];

    always #5 clk = ~clk;

    data_mem_responder #(.WORD_SIZE(16), .MEM_DEPTH(256), .LATENCY(2)) u_l2 (
        .clk(clk), .reset_n(reset_n), .d_readM(rd_v[0]), .d_writeM(wr_v[0]),
        .d_address(addr), .d_data_in(wdata), .d_data_out(dout_a[0]),
        .d_ready(ready_v[0]), .d_busy(busy_v[0]), .d_err(err_v[0]));

    data_mem_responder #(.WORD_SIZE(16), .MEM_DEPTH(256), .LATENCY(1)) u_l1 (
        .clk(clk), .reset_n(reset_n), .d_readM(rd_v[1]), .d_writeM(wr_v[1]),
        .d_address(addr), .d_data_in(wdata), .d_data_out(dout_a[1]),
        .d_ready(ready_v[1]), .d_busy(busy_v[1]), .d_err(err_v[1]));

    data_mem_responder #(.WORD_SIZE(16), .MEM_DEPTH(256), .LATENCY(4)) u_l4 (
        .clk(clk), .reset_n(reset_n), .d_readM(rd_v[2]), .d_writeM(wr_v[2]),
        .d_address(addr), .d_data_in(wdata), .d_data_out(dout_a[2]),
        .d_ready(ready_v[2]), .d_busy(busy_v[2]), .d_err(err_v[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request on responder idx and check busy/ready every cycle; with hold the
    // request stays raised through the DONE cycle and the task returns at the end of it.
    task automatic run_req(input int idx, input bit rd, input bit wr, input logic [15:0] a,
                           input logic [15:0] d, input logic [15:0] exp_d, input bit chk,
                           input bit hold, input string tag);
        exp_t e;
        int   lat;
        lat = lats[idx];
        @(posedge clk); #1;
        rd_v[idx] = rd;
        wr_v[idx] = wr;
        addr      = a;
        wdata     = d;
        e.data = exp_d;
        e.chk  = chk;
        e.err  = rd & wr;
        sb_q.push_back(e);
        for (int c = 0; c <= lat + 2; c++) begin
            if (hold && c == lat + 2) break;
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == lat + 1 && !hold) begin
                    rd_v[idx] = 1'b0;
                    wr_v[idx] = 1'b0;
                end
            end
            @(negedge clk);
            check($sformatf("%s busy c%0d", tag, c), busy_v[idx], (c <= lat));
            check($sformatf("%s ready c%0d", tag, c), ready_v[idx], (c == lat + 1));
            if (ready_v[idx] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check($sformatf("%s unexpected ready", tag), 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("%s err", tag), err_v[idx], e.err);
                    if (e.chk) check($sformatf("%s data", tag), dout_a[idx], e.data);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        lats[0] = 2; lats[1] = 1; lats[2] = 4;
        vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 16'h0105, 16'h1234, 16'hBEEF, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 16'h0020, 16'h5555, 16'h1234, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 16'h0030, 16'h1111, 16'h5555, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 16'h00FF, 16'h0F0F, 16'h5555, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 16'h01FF, 16'h0000, 16'h0F0F, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1};

        // Reset held with a read request raised.
        reset_n = 1'b0;
        rd_v    = 3'b001;
        wr_v    = 3'b000;
        addr    = 16'h0010;
        wdata   = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", busy_v[0], 1'b0);
        check("rst ready", ready_v[0], 1'b0);
        check("rst err", err_v[0], 1'b0);
        check("rst dout", dout_a[0], 16'h0000);
        reset_n = 1'b1;
        #1;
        check("release busy c0", busy_v[0], 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c == 3) rd_v[0] = 1'b0;
            @(negedge clk);
            check($sformatf("release busy c%0d", c), busy_v[0], (c <= 2));
            check($sformatf("release ready c%0d", c), ready_v[0], (c == 3));
        end

        for (int i = 0; i < 10; i++) begin
            run_req(0, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp_d,
                    vecs[i].chk, 1'b0, $sformatf("vec%0d", i));
        end

        // Reset in cycle 1 of a write must abort it without committing.
        @(posedge clk); #1;
        wr_v[0] = 1'b1;
        addr    = 16'h0030;
        wdata   = 16'hAAAA;
        @(posedge clk); #1;
        reset_n = 1'b0;
        wr_v[0] = 1'b0;
        @(negedge clk);
        check("midrst busy", busy_v[0], 1'b0);
        check("midrst ready", ready_v[0], 1'b0);
        check("midrst dout", dout_a[0], 16'h0000);
        repeat (2) @(posedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("midrst no ready %0d", c), ready_v[0], 1'b0);
        end
        run_req(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h1111, 1'b1, 1'b0, "midrst readback");

        // Request held through DONE: only one ready, then re-acceptance in IDLE.
        for (int i = 0; i < 3; i++) begin
            run_req(i, 1'b0, 1'b1, 16'h0040, 16'hC000 + 16'(i), 16'h0000, 1'b0, 1'b0,
                    $sformatf("b2b%0d wr", i));
            run_req(i, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hC000 + 16'(i), 1'b1, 1'b1,
                    $sformatf("b2b%0d rd1", i));
            run_req(i, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hC000 + 16'(i), 1'b1, 1'b0,
                    $sformatf("b2b%0d rd2", i));
        end

        check("scoreboard empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
